// File: rtl/accumulator_bank.sv
// Bank of DEPTH rows x LANES partial sums with a two-stage masked write/add pipeline,
// a registered drain read port and a one-row-per-cycle sweep-clear.
module accumulator_bank #(
    parameter  int DEPTH  = 128,
    parameter  int LANES  = 32,
    parameter  int DATA_W = 32,
    localparam int AW     = $clog2(DEPTH),
    localparam int ROW_W  = LANES * DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_accumulator_i,
    input  logic [AW-1:0]     accumulator_addr_wr_i,
    input  logic [LANES-1:0]  accum_addr_mask_i,
    input  logic              accumulator_add_i,
    input  logic [ROW_W-1:0]  accum_data_i,
    input  logic              read_accumulator_i,
    input  logic [AW-1:0]     accumulator_addr_rd_i,
    output logic [ROW_W-1:0]  accum_data_o,
    output logic              accum_valid_o,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              err_o
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

    logic [ROW_W-1:0] mem [DEPTH];

    state_t            state_reg, state_next;
    logic [AW-1:0]     clr_addr_reg, clr_addr_next;
    logic              busy;

    logic              wr_addr_ok, rd_addr_ok;
    logic              wr_accept, rd_accept, drop;
    logic              s1_fwd, rd_fwd;

    logic              s2_valid_reg;
    logic [AW-1:0]     s2_addr_reg;
    logic [LANES-1:0]  s2_mask_reg;
    logic              s2_add_reg;
    logic [ROW_W-1:0]  s2_data_reg;
    logic [ROW_W-1:0]  old_row_reg;
    logic [ROW_W-1:0]  s2_result;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [ROW_W-1:0]  mem_wdata;

    logic [ROW_W-1:0]  accum_data_reg;
    logic              accum_valid_reg;
    logic              err_reg;

    // Sweep-clear controller
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            IDLE: begin
                if (clear_i) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            CLEAR: begin
                clr_addr_next = clr_addr_reg + AW'(1);
                if (clr_addr_reg == LAST_ROW) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == CLEAR);

    // Out-of-range rows only exist when DEPTH is not a power of two
    generate
        if ((1 << AW) == DEPTH) begin : g_pow2
            assign wr_addr_ok = 1'b1;
            assign rd_addr_ok = 1'b1;
        end else begin : g_npow2
            localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
            assign wr_addr_ok = (accumulator_addr_wr_i < DEPTH_A);
            assign rd_addr_ok = (accumulator_addr_rd_i < DEPTH_A);
        end
    endgenerate

    assign wr_accept = write_accumulator_i && !busy && wr_addr_ok;
    assign rd_accept = read_accumulator_i && !busy;
    assign drop      = busy && (write_accumulator_i || read_accumulator_i);

    // A request to the row being committed this cycle must see the new value
    assign s1_fwd = s2_valid_reg && (s2_addr_reg == accumulator_addr_wr_i);
    assign rd_fwd = s2_valid_reg && (s2_addr_reg == accumulator_addr_rd_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_reg <= 1'b0;
        end else begin
            s2_valid_reg <= wr_accept;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            s2_addr_reg <= accumulator_addr_wr_i;
            s2_mask_reg <= accum_addr_mask_i;
            s2_add_reg  <= accumulator_add_i;
            s2_data_reg <= accum_data_i;
            old_row_reg <= s1_fwd ? s2_result : mem[accumulator_addr_wr_i];
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] old_lane;
            logic [DATA_W-1:0] in_lane;
            logic [DATA_W-1:0] new_lane;
            assign old_lane = old_row_reg[gi*DATA_W +: DATA_W];
            assign in_lane  = s2_data_reg[gi*DATA_W +: DATA_W];
            assign new_lane = s2_add_reg ? (old_lane + in_lane) : in_lane;
            // Mask is MSB-first: bit LANES-1 enables lane 0
            assign s2_result[gi*DATA_W +: DATA_W] = s2_mask_reg[LANES-1-gi] ? new_lane : old_lane;
        end
    endgenerate

    // Clear owns the write port; a write caught in flight is superseded by the sweep
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = s2_addr_reg;
        mem_wdata = s2_result;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_reg;
            mem_wdata = '0;
        end else if (s2_valid_reg) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            accum_data_reg  <= '0;
            accum_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            accum_valid_reg <= rd_accept;
            if (rd_accept) begin
                if (!rd_addr_ok) begin
                    accum_data_reg <= '0;
                end else if (rd_fwd) begin
                    accum_data_reg <= s2_result;
                end else begin
                    accum_data_reg <= mem[accumulator_addr_rd_i];
                end
            end
            if (drop) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign accum_data_o  = accum_data_reg;
    assign accum_valid_o = accum_valid_reg;
    assign busy_o        = busy;
    assign err_o         = err_reg;

endmodule

// File: tb/tb_accumulator_bank.sv
// Bench for accumulator_bank: directed scenarios plus random traffic checked against
// a lane-array model that applies each accepted write immediately in request order.
module tb_accumulator_bank;

    localparam int DEPTH  = 128;
    localparam int LANES  = 32;
    localparam int DATA_W = 32;
    localparam int AW     = 7;
    localparam int ROW_W  = LANES * DATA_W;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              write_accumulator_i;
    logic [AW-1:0]     accumulator_addr_wr_i;
    logic [LANES-1:0]  accum_addr_mask_i;
    logic              accumulator_add_i;
    logic [ROW_W-1:0]  accum_data_i;
    logic              read_accumulator_i;
    logic [AW-1:0]     accumulator_addr_rd_i;
    logic [ROW_W-1:0]  accum_data_o;
    logic              accum_valid_o;
    logic              clear_i;
    logic              busy_o;
    logic              err_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DATA_W-1:0] model_mem [DEPTH][LANES];

    always #5 clk_i = ~clk_i;

    accumulator_bank #(.DEPTH(DEPTH), .LANES(LANES), .DATA_W(DATA_W)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .write_accumulator_i   (write_accumulator_i),
        .accumulator_addr_wr_i (accumulator_addr_wr_i),
        .accum_addr_mask_i     (accum_addr_mask_i),
        .accumulator_add_i     (accumulator_add_i),
        .accum_data_i          (accum_data_i),
        .read_accumulator_i    (read_accumulator_i),
        .accumulator_addr_rd_i (accumulator_addr_rd_i),
        .accum_data_o          (accum_data_o),
        .accum_valid_o         (accum_valid_o),
        .clear_i               (clear_i),
        .busy_o                (busy_o),
        .err_o                 (err_o)
    );

    function automatic logic [DATA_W-1:0] lane(logic [ROW_W-1:0] r, int i);
        return r[i*DATA_W +: DATA_W];
    endfunction

    function automatic int first_diff(logic [ROW_W-1:0] a, logic [ROW_W-1:0] b);
        for (int i = 0; i < LANES; i++) begin
            if (a[i*DATA_W +: DATA_W] !== b[i*DATA_W +: DATA_W]) return i;
        end
        return 0;
    endfunction

    function automatic logic [ROW_W-1:0] fill(logic [DATA_W-1:0] v);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] ramp(int base);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(i + base);
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] model_row(int a);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = model_mem[a][i];
        return r;
    endfunction

    task automatic model_apply(int a, logic [LANES-1:0] m, logic ad, logic [ROW_W-1:0] d);
        for (int i = 0; i < LANES; i++) begin
            if (m[LANES-1-i]) begin
                model_mem[a][i] = ad ? model_mem[a][i] + d[i*DATA_W +: DATA_W] : d[i*DATA_W +: DATA_W];
            end
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++)
            for (int i = 0; i < LANES; i++) model_mem[a][i] = '0;
    endtask

    task automatic set_idle();
        write_accumulator_i   = 1'b0;
        accumulator_addr_wr_i = '0;
        accum_addr_mask_i     = '0;
        accumulator_add_i     = 1'b0;
        accum_data_i          = '0;
        read_accumulator_i    = 1'b0;
        accumulator_addr_rd_i = '0;
        clear_i               = 1'b0;
    endtask

    task automatic tick();
        if (write_accumulator_i || read_accumulator_i || clear_i || rst_i)
            $display("cyc %0d wr=%0b@%0d add=%0b mask=%h rd=%0b@%0d clr=%0b rst=%0b", cyc,
                     write_accumulator_i, accumulator_addr_wr_i, accumulator_add_i, accum_addr_mask_i,
                     read_accumulator_i, accumulator_addr_rd_i, clear_i, rst_i);
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // Expected read data is the model row before this cycle's write is applied
    task automatic run_cycle(output logic [ROW_W-1:0] exp);
        exp = model_row(int'(accumulator_addr_rd_i));
        if (write_accumulator_i)
            model_apply(int'(accumulator_addr_wr_i), accum_addr_mask_i, accumulator_add_i, accum_data_i);
        tick();
    endtask

    task automatic put_write(int a, logic [LANES-1:0] m, logic ad, logic [ROW_W-1:0] d);
        write_accumulator_i   = 1'b1;
        accumulator_addr_wr_i = AW'(a);
        accum_addr_mask_i     = m;
        accumulator_add_i     = ad;
        accum_data_i          = d;
    endtask

    task automatic put_read(int a);
        read_accumulator_i    = 1'b1;
        accumulator_addr_rd_i = AW'(a);
    endtask

    task automatic do_clear();
        int cnt;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        cnt = 0;
        while (busy_o === 1'b1 && cnt < DEPTH + 10) begin
            cnt++;
            tick();
        end
        model_clear();
        n_vec++;
        if (cnt !== DEPTH) begin
            n_err++;
            $display("FAIL clear_busy_len: got %0d cycles, required %0d", cnt, DEPTH);
        end
    endtask

    task automatic test_reset();
        set_idle();
        rst_i = 1'b1;
        tick();
        tick();
        n_vec++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
        n_vec++;
        if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b, required 0", err_o); end
        n_vec++;
        if (accum_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", accum_valid_o); end
        n_vec++;
        if (accum_data_o !== '0) begin n_err++; $display("FAIL reset_data: lane0 got %h, required 0", lane(accum_data_o, 0)); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        do_clear();
        n_vec++;
        if (err_o !== 1'b0) begin n_err++; $display("FAIL clear_err: got %b, required 0", err_o); end
    endtask

    task automatic test_overwrite_add();
        logic [ROW_W-1:0] exp;
        logic [ROW_W-1:0] wdat [3];
        int d;
        wdat[0] = ramp(0);
        wdat[1] = fill(32'd1);
        wdat[2] = fill(32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            set_idle();
            put_write(5, '1, (k != 0), wdat[k]);
            run_cycle(exp);
            set_idle();
            put_read(5);
            run_cycle(exp);
            n_vec++;
            if (accum_valid_o !== 1'b1 || accum_data_o !== exp) begin
                n_err++;
                d = first_diff(accum_data_o, exp);
                $display("FAIL overwrite_add step %0d: valid=%b lane%0d=%h, required valid=1 lane%0d=%h",
                         k, accum_valid_o, d, lane(accum_data_o, d), d, lane(exp, d));
            end
        end
        set_idle();
    endtask

    task automatic test_mask();
        logic [ROW_W-1:0] exp;
        int d;
        set_idle();
        put_write(9, 32'h8000_0000, 1'b0, fill(32'd7));
        run_cycle(exp);
        put_write(9, 32'h7FFF_FFFF, 1'b1, fill(32'd2));
        run_cycle(exp);
        put_write(9, 32'h0000_0000, 1'b1, fill(32'd5));
        run_cycle(exp);
        set_idle();
        put_read(9);
        run_cycle(exp);
        n_vec++;
        if (accum_valid_o !== 1'b1 || accum_data_o !== exp) begin
            n_err++;
            d = first_diff(accum_data_o, exp);
            $display("FAIL lane_mask: valid=%b lane%0d=%h, required valid=1 lane%0d=%h",
                     accum_valid_o, d, lane(accum_data_o, d), d, lane(exp, d));
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        logic [ROW_W-1:0] exp;
        int d;
        set_idle();
        for (int k = 0; k < 3; k++) begin
            put_write(3, '1, 1'b1, fill(32'd1));
            run_cycle(exp);
        end
        set_idle();
        put_read(3);
        run_cycle(exp);
        n_vec++;
        if (accum_valid_o !== 1'b1 || accum_data_o !== exp) begin
            n_err++;
            d = first_diff(accum_data_o, exp);
            $display("FAIL back_to_back: valid=%b lane%0d=%h, required valid=1 lane%0d=%h",
                     accum_valid_o, d, lane(accum_data_o, d), d, lane(exp, d));
        end
        set_idle();
    endtask

    task automatic test_read_during_write();
        logic [ROW_W-1:0] exp;
        int d;
        set_idle();
        put_write(4, '1, 1'b0, fill(32'd9));
        put_read(4);
        for (int k = 0; k < 2; k++) begin
            run_cycle(exp);
            n_vec++;
            if (accum_valid_o !== 1'b1 || accum_data_o !== exp) begin
                n_err++;
                d = first_diff(accum_data_o, exp);
                $display("FAIL read_during_write read %0d: valid=%b lane%0d=%h, required valid=1 lane%0d=%h",
                         k, accum_valid_o, d, lane(accum_data_o, d), d, lane(exp, d));
            end
            write_accumulator_i = 1'b0;
        end
        set_idle();
    endtask

    task automatic test_random();
        logic [ROW_W-1:0] exp;
        logic [ROW_W-1:0] last_exp;
        logic [ROW_W-1:0] rdat;
        logic [LANES-1:0] m;
        bit have_last;
        int d;
        have_last = 1'b0;
        for (int k = 0; k < 400; k++) begin
            set_idle();
            if ($urandom_range(0, 2) != 0) begin
                for (int i = 0; i < LANES; i++)
                    rdat[i*DATA_W +: DATA_W] = ($urandom_range(0, 1) == 1) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 15));
                case ($urandom_range(0, 7))
                    0:       m = '0;
                    1, 2:    m = '1;
                    default: m = LANES'($urandom);
                endcase
                put_write(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 5),
                          m, ($urandom_range(0, 3) != 0), rdat);
            end
            if ($urandom_range(0, 1) == 1)
                put_read(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 5));
            run_cycle(exp);
            n_vec++;
            if (read_accumulator_i) begin
                if (accum_valid_o !== 1'b1 || accum_data_o !== exp) begin
                    n_err++;
                    d = first_diff(accum_data_o, exp);
                    $display("FAIL random_read %0d row %0d: valid=%b lane%0d=%h, required valid=1 lane%0d=%h",
                             k, accumulator_addr_rd_i, accum_valid_o, d, lane(accum_data_o, d), d, lane(exp, d));
                end
                last_exp  = exp;
                have_last = 1'b1;
            end else if (accum_valid_o !== 1'b0 || (have_last && accum_data_o !== last_exp)) begin
                n_err++;
                d = first_diff(accum_data_o, last_exp);
                $display("FAIL random_idle %0d: valid=%b lane%0d=%h, required valid=0 lane%0d=%h",
                         k, accum_valid_o, d, lane(accum_data_o, d), d, lane(last_exp, d));
            end
        end
        set_idle();
    endtask

    task automatic test_clear_collision();
        logic [ROW_W-1:0] exp;
        int cnt;
        int d;
        set_idle();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        cnt = 0;
        while (busy_o === 1'b1 && cnt < DEPTH + 10) begin
            cnt++;
            set_idle();
            if (cnt == 10) put_write(2, '1, 1'b0, ramp(1));
            if (cnt == 20) put_read(2);
            if (cnt == 30) clear_i = 1'b1;
            tick();
            if (cnt == 20) begin
                n_vec++;
                if (accum_valid_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL clear_read_dropped: valid got %b, required 0", accum_valid_o);
                end
            end
        end
        set_idle();
        model_clear();
        n_vec++;
        if (cnt !== DEPTH) begin n_err++; $display("FAIL collision_busy_len: got %0d cycles, required %0d", cnt, DEPTH); end
        n_vec++;
        if (err_o !== 1'b1) begin n_err++; $display("FAIL clear_err_sticky: got %b, required 1", err_o); end
        for (int a = 0; a < DEPTH; a++) begin
            set_idle();
            put_read(a);
            run_cycle(exp);
            n_vec++;
            if (accum_valid_o !== 1'b1 || accum_data_o !== exp) begin
                n_err++;
                d = first_diff(accum_data_o, exp);
                $display("FAIL cleared_row %0d: valid=%b lane%0d=%h, required valid=1 lane%0d=%h",
                         a, accum_valid_o, d, lane(accum_data_o, d), d, lane(exp, d));
            end
        end
        set_idle();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int k = 1; k < 50; k++) tick();
        n_vec++;
        if (busy_o !== 1'b1) begin n_err++; $display("FAIL midclear_busy: got %b, required 1", busy_o); end
        rst_i = 1'b1;
        tick();
        n_vec++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL midclear_reset_busy: got %b, required 0", busy_o); end
        n_vec++;
        if (err_o !== 1'b0) begin n_err++; $display("FAIL midclear_reset_err: got %b, required 0", err_o); end
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_i = 1'b1;
        set_idle();
        test_reset();
        test_clear();
        test_overwrite_add();
        test_mask();
        test_back_to_back();
        test_read_during_write();
        test_random();
        test_clear_collision();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
